// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Instruction prefetcher. It issues sequential 32-bit reads on an Avalon-MM
//   read host port and buffers the returned words, each with its fetch
//   address, in a small prefetch queue. A redirect flushes the queue and
//   restarts fetching at a new address. Responses to reads issued before the
//   redirect are dropped.
//
// Parameters:
//   DEPTH     prefetch queue entries (power of two, 2..8)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   redirect/redirect_pc flush and restart fetching at redirect_pc
//   ins_valid/ins_ready  handshake on the queue head
//   ins_word/ins_pc      head instruction and its fetch address
//   fault                misaligned redirect seen (only with the macro below)
//   avm_*                Avalon-MM read host (byteenable is always 4'b1111)
//
// Compile-time option:
//   IFETCH_ALIGN_CHECK_EN  A misaligned redirect halts fetching and raises
//                          fault. Without it, redirect_pc[1:0] is forced to 0
//                          and fault is tied low.
// ---------------------------------------------------------------------------
`default_nettype none

module instruction_fetch #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_word,
    output logic [31:0] ins_pc,
    output logic        fault,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        rsp_pc_q, rsp_pc_d;
    logic               avm_read_q, avm_read_d;
    logic [31:0]        avm_address_q, avm_address_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   live_q, live_d;
    logic [CNT_W-1:0]   stale_q, stale_d;
    logic               pend_stale_q, pend_stale_d;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic               fault_q, fault_d;
`endif

    logic [31:0]        data_mem [DEPTH];
    logic [31:0]        pc_mem   [DEPTH];

    logic               accept;
    logic               rsp_drop;
    logic               rsp_live;
    logic               redir_take;
    logic               push;
    logic               pop;
    logic               misaligned;
    logic [31:0]        redir_pc_eff;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign redir_pc_eff = redirect_pc;
    assign misaligned   = |redirect_pc[1:0];
    assign fault        = fault_q;
`else
    assign redir_pc_eff = redirect_pc & 32'hFFFF_FFFC;
    assign misaligned   = 1'b0;
    assign fault        = 1'b0;
`endif

    assign accept     = avm_read_q & ~avm_waitrequest;
    // Responses come back in order, so the stale ones are always the oldest.
    // Dropping while the stale count is nonzero discards exactly those.
    assign rsp_drop   = avm_readdatavalid & (stale_q != '0);
    assign rsp_live   = avm_readdatavalid & (stale_q == '0);
    assign redir_take = redirect & (state_q != HALT);
    assign push       = rsp_live & ~redir_take;
    assign pop        = ins_valid & ins_ready;

    assign ins_valid      = (count_q != '0);
    assign ins_word       = data_mem[rd_ptr_q];
    assign ins_pc         = pc_mem[rd_ptr_q];
    assign avm_read       = avm_read_q;
    assign avm_address    = avm_address_q;
    assign avm_byteenable = 4'b1111;

    // Next-state computation for the whole block. Live reads are accepted
    // reads whose responses will enter the queue. Stale reads are accepted
    // reads whose responses will be dropped. Live responses always belong to
    // consecutive addresses starting at the last restart point, so rsp_pc
    // tracks the address of the next live response. No per-read address
    // FIFO is needed.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        live_d        = live_q;
        stale_d       = stale_q;
        pend_stale_d  = pend_stale_q;
        avm_read_d    = 1'b0;
        avm_address_d = 32'h0;
`ifdef IFETCH_ALIGN_CHECK_EN
        fault_d       = fault_q;
`endif

        // A read that was already pending when a redirect arrived completes
        // with its old address. It becomes stale and does not advance fetch_pc,
        // which by then holds the redirect target.
        if (accept) begin
            if (pend_stale_q) begin
                stale_d      = stale_d + CNT_W'(1);
                pend_stale_d = 1'b0;
            end else begin
                live_d     = live_d + CNT_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end
        if (rsp_drop) begin
            stale_d = stale_d - CNT_W'(1);
        end
        if (rsp_live) begin
            live_d = live_d - CNT_W'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = RUN;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        // A redirect turns every live read into a stale one. This includes
        // a read accepted in this same cycle. A live response arriving now is
        // old data and is not pushed.
        if (redir_take) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            stale_d    = stale_d + live_d;
            live_d     = '0;
            fetch_pc_d = redir_pc_eff;
            rsp_pc_d   = redir_pc_eff;
            if (avm_read_q && avm_waitrequest) begin
                pend_stale_d = 1'b1;
            end
            if (misaligned) begin
                state_d = HALT;
`ifdef IFETCH_ALIGN_CHECK_EN
                fault_d = 1'b1;
`endif
            end
        end

        // A stalled read stays on the bus unchanged, even across a redirect
        // or a halt. A new read needs a free queue slot for every live read.
        // Live plus stale reads are also kept below DEPTH, so the stale
        // counter can never overflow across repeated redirects.
        if (avm_read_q && avm_waitrequest) begin
            avm_read_d    = 1'b1;
            avm_address_d = avm_address_q;
        end else if ((state_q == RUN) && (state_d == RUN)
                     && (({1'b0, count_d} + {1'b0, live_d}) < DEPTH_S)
                     && (({1'b0, stale_d} + {1'b0, live_d}) < DEPTH_S)) begin
            avm_read_d    = 1'b1;
            avm_address_d = fetch_pc_d;
        end
    end

    // State register. Reads outstanding at reset are abandoned along with
    // the counters that tracked them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            avm_read_q    <= 1'b0;
            avm_address_q <= 32'h0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            live_q        <= '0;
            stale_q       <= '0;
            pend_stale_q  <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            live_q        <= live_d;
            stale_q       <= stale_d;
            pend_stale_q  <= pend_stale_d;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_q       <= fault_d;
`endif
        end
    end

    // Queue storage has no reset. count_q alone decides which entries are
    // valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= avm_readdata;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Purpose:
//   Self-checking bench for instruction_fetch (DEPTH=2, RESET_PC=0x100).
//   A small Avalon memory model returns mem_word(address) after a
//   configurable number of cycles. The bench logs accepted read addresses
//   and popped instructions and compares them with hand-derived values.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int unsigned DEPTH    = 2;

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_pc0;
        logic [31:0] exp_pc1;
    } redir_vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [31:0] ins_word;
    logic [31:0] ins_pc;
    logic        fault;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    int checks = 0;
    int errors = 0;

    logic [31:0] acc_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_word[$];

    logic        rsp_v [8];
    logic [31:0] rsp_a [8];
    logic [2:0]  rsp_sel = 3'd0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .ins_valid         (ins_valid),
        .ins_ready         (ins_ready),
        .ins_word          (ins_word),
        .ins_pc            (ins_pc),
        .fault             (fault),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    // Memory model: an accepted read returns its data rsp_sel+1 cycles later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                rsp_v[i] <= 1'b0;
                rsp_a[i] <= 32'h0;
            end
        end else begin
            rsp_v[0] <= avm_read && !avm_waitrequest;
            rsp_a[0] <= avm_address;
            for (int i = 1; i < 8; i++) begin
                rsp_v[i] <= rsp_v[i-1];
                rsp_a[i] <= rsp_a[i-1];
            end
        end
    end

    assign avm_readdatavalid = rsp_v[rsp_sel];
    assign avm_readdata      = rsp_v[rsp_sel] ? mem_word(rsp_a[rsp_sel]) : 32'h0;

    // Logs of accepted read addresses and consumed instructions.
    always @(posedge clk) begin
        if (rst) begin
            if (avm_read && !avm_waitrequest) acc_log.push_back(avm_address);
            if (ins_valid && ins_ready) begin
                pop_pc.push_back(ins_pc);
                pop_word.push_back(ins_word);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic note_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting", name);
    endtask

    task automatic clear_logs();
        acc_log.delete();
        pop_pc.delete();
        pop_word.delete();
    endtask

    task automatic reset_dut(input int lat, input logic ready);
        rst             = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        avm_waitrequest = 1'b0;
        ins_ready       = ready;
        rsp_sel         = 3'(lat - 1);
        repeat (3) @(negedge clk);
        checkOutput("reset ins_valid", 32'(ins_valid), 32'd0);
        checkOutput("reset avm_read", 32'(avm_read), 32'd0);
        checkOutput("reset avm_address", avm_address, 32'h0);
        checkOutput("reset fault", 32'(fault), 32'd0);
        clear_logs();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle cycle no read", 32'(avm_read), 32'd0);
        @(negedge clk);
        checkOutput("first read asserted", 32'(avm_read), 32'd1);
        checkOutput("first read address", avm_address, RESET_PC);
        checkOutput("byteenable", 32'(avm_byteenable), 32'hF);
    endtask

    task automatic applyStimulus(input logic [31:0] target);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = target;
        @(negedge clk);
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        clear_logs();
    endtask

    task automatic wait_pops(input int n, input string name);
        int cyc = 0;
        while (pop_pc.size() < n && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        if (pop_pc.size() < n) note_timeout(name);
    endtask

    task automatic wait_acc(input int n, input string name);
        int cyc = 0;
        while (acc_log.size() < n && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        if (acc_log.size() < n) note_timeout(name);
    endtask

    initial begin
        redir_vec_t vecs[$];
        int cyc;

        vecs.push_back('{32'h0000_0400, 32'h0000_0400, 32'h0000_0404});
        vecs.push_back('{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000});
        vecs.push_back('{32'h0000_1230, 32'h0000_1230, 32'h0000_1234});
`ifndef IFETCH_ALIGN_CHECK_EN
        vecs.push_back('{32'h0000_0202, 32'h0000_0200, 32'h0000_0204});
`endif

        // Streaming from reset with zero-wait memory.
        reset_dut(1, 1'b1);
        wait_pops(3, "stream pops");
        if (pop_pc.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("stream pc%0d", i), pop_pc[i], RESET_PC + 32'(4 * i));
                checkOutput($sformatf("stream word%0d", i), pop_word[i],
                            mem_word(RESET_PC + 32'(4 * i)));
                checkOutput($sformatf("stream fetch%0d", i), acc_log[i],
                            RESET_PC + 32'(4 * i));
            end
        end

        // Redirect vectors applied while streaming.
        for (int v = 0; v < vecs.size(); v++) begin
            applyStimulus(vecs[v].target);
            checkOutput($sformatf("redir %h flush", vecs[v].target), 32'(ins_valid), 32'd0);
            wait_pops(2, $sformatf("redir %h pops", vecs[v].target));
            if (pop_pc.size() >= 2) begin
                checkOutput($sformatf("redir %h pc0", vecs[v].target), pop_pc[0], vecs[v].exp_pc0);
                checkOutput($sformatf("redir %h word0", vecs[v].target), pop_word[0],
                            mem_word(vecs[v].exp_pc0));
                checkOutput($sformatf("redir %h pc1", vecs[v].target), pop_pc[1], vecs[v].exp_pc1);
            end
            if (acc_log.size() >= 1) begin
                checkOutput($sformatf("redir %h fetch0", vecs[v].target), acc_log[0],
                            vecs[v].exp_pc0);
            end
            checkOutput($sformatf("redir %h fault", vecs[v].target), 32'(fault), 32'd0);
        end

        // Backpressure: the queue fills with 0x100/0x104 and fetching stops.
        reset_dut(1, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("bp reads issued", 32'(acc_log.size()), 32'd2);
        checkOutput("bp no read", 32'(avm_read), 32'd0);
        checkOutput("bp head valid", 32'(ins_valid), 32'd1);
        checkOutput("bp head pc", ins_pc, 32'h0000_0100);
        checkOutput("bp head word", ins_word, mem_word(32'h0000_0100));
        ins_ready = 1'b1;
        @(negedge clk);
        ins_ready = 1'b0;
        checkOutput("bp after pop valid", 32'(ins_valid), 32'd1);
        checkOutput("bp after pop pc", ins_pc, 32'h0000_0104);
        checkOutput("bp refill read", 32'(avm_read), 32'd1);
        checkOutput("bp refill address", avm_address, 32'h0000_0108);

        // Redirect with two reads outstanding (3-cycle memory latency).
        reset_dut(3, 1'b1);
        wait_acc(2, "two outstanding");
        checkOutput("outstanding queue empty", 32'(ins_valid), 32'd0);
        applyStimulus(32'h0000_0400);
        wait_pops(1, "outstanding redirect pop");
        if (pop_pc.size() >= 1) begin
            checkOutput("outstanding redirect pc", pop_pc[0], 32'h0000_0400);
            checkOutput("outstanding redirect word", pop_word[0], mem_word(32'h0000_0400));
        end
        if (acc_log.size() >= 1) checkOutput("outstanding refetch", acc_log[0], 32'h0000_0400);

        // Redirect while the read of 0x108 is stalled by waitrequest.
        reset_dut(1, 1'b1);
        cyc = 0;
        while (!(avm_read && avm_address == 32'h0000_0108) && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        if (!(avm_read && avm_address == 32'h0000_0108)) begin
            note_timeout("wait read 0x108");
        end
        avm_waitrequest = 1'b1;
        redirect        = 1'b1;
        redirect_pc     = 32'h0000_0200;
        @(negedge clk);
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        clear_logs();
        checkOutput("stall flush", 32'(ins_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("stall hold read %0d", i), 32'(avm_read), 32'd1);
            checkOutput($sformatf("stall hold addr %0d", i), avm_address, 32'h0000_0108);
            if (i < 2) @(negedge clk);
        end
        avm_waitrequest = 1'b0;
        wait_acc(2, "stall release");
        if (acc_log.size() >= 2) begin
            checkOutput("stall old read", acc_log[0], 32'h0000_0108);
            checkOutput("stall new read", acc_log[1], 32'h0000_0200);
        end
        wait_pops(1, "stall redirect pop");
        if (pop_pc.size() >= 1) checkOutput("stall redirect pc", pop_pc[0], 32'h0000_0200);

`ifdef IFETCH_ALIGN_CHECK_EN
        // Misaligned redirect halts fetching and raises fault.
        reset_dut(1, 1'b1);
        repeat (4) @(negedge clk);
        applyStimulus(32'h0000_0202);
        checkOutput("misalign fault", 32'(fault), 32'd1);
        checkOutput("misalign flush", 32'(ins_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("misalign no read %0d", i), 32'(avm_read), 32'd0);
            @(negedge clk);
        end
        checkOutput("misalign fault held", 32'(fault), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
